// File: rtl/pixel_plot_receiver_pkg.sv
// Shared widths, FSM encodings and the plot FIFO entry type for the pixel-plot receiver.
package pixel_plot_receiver_pkg;

    localparam int ADDR_W  = 15;
    localparam int COLOR_W = 3;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } plot_entry_t;

    // Linear framebuffer address; the product always fits ADDR_W for in-range plots.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] px,
                                                     input logic [Y_W-1:0] py,
                                                     input int screen_w);
        return ADDR_W'(py) * ADDR_W'(screen_w) + ADDR_W'(px);
    endfunction

endpackage

// File: rtl/pixel_plot_receiver_fifo.sv
// Small synchronous FIFO of {addr, color} plot entries with a flush that wins over push/pop.
module pixel_fifo
    import pixel_plot_receiver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        push,
    input  plot_entry_t push_data,
    input  logic        pop,
    output plot_entry_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    plot_entry_t      mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_plot_receiver.sv
// Receives pixel plots, bounds-checks and queues them, and writes them into the shared
// single-port framebuffer RAM alongside scanout reads and a full-screen clear sweep.
module pixel_plot_receiver
    import pixel_plot_receiver_pkg::*;
#(
    parameter int                 SCREEN_W    = 160,
    parameter int                 SCREEN_H    = 120,
    parameter int                 FIFO_DEPTH  = 4,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = 3'b000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic [COLOR_W-1:0] color,
    input  logic               plot,
    output logic               ready,
    input  logic               clear,
    output logic               clearDone,
    input  logic               scanReq,
    input  logic [ADDR_W-1:0]  scanAddr,
    output logic [COLOR_W-1:0] scanData,
    output logic               scanValid,
    output logic [ADDR_W-1:0]  memAddr,
    output logic [COLOR_W-1:0] memData,
    output logic               memWren,
    input  logic [COLOR_W-1:0] memQ,
    output logic [7:0]         dropCount,
    output logic               busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0] mem_data_q, mem_data_d;
    logic               mem_wren_q, mem_wren_d;
    logic               clear_done_q, clear_done_d;
    logic [1:0]         scan_pipe_q, scan_pipe_d;
    logic [7:0]         drop_count_q, drop_count_d;

    logic        in_range;
    logic        accept;
    logic        clear_start;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    plot_entry_t push_entry;
    plot_entry_t pop_entry;

    assign in_range    = (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
    assign ready       = resetn && (state_q == ST_RUN) && !fifo_full;
    assign accept      = plot && ready;
    assign clear_start = clear && (state_q == ST_RUN);
    // A plot arriving with the clear request is lost to the flush.
    assign fifo_push   = accept && in_range && !clear_start;
    assign push_entry  = {pixel_addr(x, y, SCREEN_W), color};

    pixel_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (clear_start),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .pop_data (pop_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_wren_d   = 1'b0;
        clear_done_d = 1'b0;
        fifo_pop     = 1'b0;
        scan_pipe_d  = {scan_pipe_q[0], scanReq};
        drop_count_d = drop_count_q;

        if (accept && !in_range && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end

        // Single RAM port: scanout, then the clear sweep, then queued plots.
        if (scanReq) begin
            mem_addr_d = scanAddr;
        end else if (state_q == ST_CLEAR) begin
            mem_addr_d = clr_cnt_q;
            mem_data_d = CLEAR_COLOR;
            mem_wren_d = 1'b1;
            clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == LAST_ADDR) begin
                state_d      = ST_RUN;
                clear_done_d = 1'b1;
            end
        end else if (!fifo_empty && !clear_start) begin
            fifo_pop   = 1'b1;
            mem_addr_d = pop_entry.addr;
            mem_data_d = pop_entry.color;
            mem_wren_d = 1'b1;
        end

        if (clear_start) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_RUN;
            clr_cnt_q    <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wren_q   <= 1'b0;
            clear_done_q <= 1'b0;
            scan_pipe_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wren_q   <= mem_wren_d;
            clear_done_q <= clear_done_d;
            scan_pipe_q  <= scan_pipe_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign memAddr   = mem_addr_q;
    assign memData   = mem_data_q;
    assign memWren   = mem_wren_q;
    assign clearDone = clear_done_q;
    assign scanValid = scan_pipe_q[1];
    assign scanData  = scan_pipe_q[1] ? memQ : '0;
    assign dropCount = drop_count_q;
    assign busy      = !fifo_empty || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_pixel_plot_receiver.sv
// Randomized self-checking bench for pixel_plot_receiver with a RAM model and a
// framebuffer/write-order reference model.
module tb_pixel_plot_receiver;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic [2:0]  color = '0;
    logic        plot = 1'b0;
    logic        ready;
    logic        clear = 1'b0;
    logic        clearDone;
    logic        scanReq = 1'b0;
    logic [14:0] scanAddr = '0;
    logic [2:0]  scanData;
    logic        scanValid;
    logic [14:0] memAddr;
    logic [2:0]  memData;
    logic        memWren;
    logic [2:0]  memQ;
    logic [7:0]  dropCount;
    logic        busy;

    always #5 clk = ~clk;

    pixel_plot_receiver dut (
        .clk      (clk),
        .resetn   (resetn),
        .x        (x),
        .y        (y),
        .color    (color),
        .plot     (plot),
        .ready    (ready),
        .clear    (clear),
        .clearDone(clearDone),
        .scanReq  (scanReq),
        .scanAddr (scanAddr),
        .scanData (scanData),
        .scanValid(scanValid),
        .memAddr  (memAddr),
        .memData  (memData),
        .memWren  (memWren),
        .memQ     (memQ),
        .dropCount(dropCount),
        .busy     (busy)
    );

    // Framebuffer RAM: registered read of the address sampled at the edge.
    logic [2:0] ram [NPIX];
    always @(posedge clk) begin
        if (memWren === 1'b1) ram[memAddr] <= memData;
        memQ <= ram[memAddr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected RAM writes in order, picture contents, drop counter.
    logic [17:0] exp_q [$];
    logic [2:0]  fb [NPIX];
    int          written_addrs [$];
    int          model_drop = 0;
    int          wr_count = 0;
    int          done_count = 0;
    logic [17:0] mon_exp;
    logic        req_d1 = 1'b0;
    logic        req_d2 = 1'b0;

    always @(posedge clk) begin
        req_d1 <= resetn && scanReq;
        req_d2 <= resetn && req_d1;
    end

    always @(negedge clk) begin
        if (memWren === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", 32'(memWren), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("write", 32'({memAddr, memData}), 32'(mon_exp));
            end
        end
        if (clearDone === 1'b1) begin
            done_count++;
            check_val("clear_done_at_last", 32'({memWren, memAddr}), 32'({1'b1, 15'(NPIX - 1)}));
        end
        if (req_d2 || (scanValid !== 1'b0)) check_val("scan_valid", 32'(scanValid), 32'(req_d2));
    end

    task automatic model_accept(input int px, input int py, input int pc);
        int a;
        if (px < W && py < H) begin
            a = py * W + px;
            exp_q.push_back({15'(a), 3'(pc)});
            fb[a] = 3'(pc);
            written_addrs.push_back(a);
            $display("plot (%0d,%0d) color %0d -> addr %0d", px, py, pc, a);
        end else begin
            if (model_drop < 255) model_drop++;
            $display("plot (%0d,%0d) out of range -> dropped, count %0d", px, py, model_drop);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back({15'(i), 3'b000});
            fb[i] = 3'b000;
        end
        $display("clear requested: %0d writes of 0 expected", NPIX);
    endtask

    // All driving tasks start and end just after a rising edge.
    task automatic send_plot(input int px, input int py, input int pc);
        bit acc;
        bit done;
        done = 1'b0;
        x = 8'(px); y = 7'(py); color = 3'(pc); plot = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk); acc = (ready === 1'b1);
            @(posedge clk);
            if (acc) begin
                model_accept(px, py, pc);
                done = 1'b1;
            end
            #1;
        end
        plot = 1'b0;
        if (!done) check_val("plot_accept", 32'(ready), 32'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (busy === 1'b0 && exp_q.size() == 0) break;
        end
        @(posedge clk); #1;
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic scan_read(input int a);
        scanReq = 1'b1; scanAddr = 15'(a);
        @(posedge clk); #1;
        scanReq = 1'b0;
        @(negedge clk);
        check_val("scan_no_write", 32'(memWren), 32'd0);
        @(posedge clk); @(negedge clk);
        check_val("scan_data", 32'(scanData), 32'(fb[a]));
        $display("scan addr %0d -> data %0d (model %0d)", a, scanData, fb[a]);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_ready"},     32'(ready),     32'd0);
        check_val({pfx, "_clearDone"}, 32'(clearDone), 32'd0);
        check_val({pfx, "_scanValid"}, 32'(scanValid), 32'd0);
        check_val({pfx, "_scanData"},  32'(scanData),  32'd0);
        check_val({pfx, "_memAddr"},   32'(memAddr),   32'd0);
        check_val({pfx, "_memData"},   32'(memData),   32'd0);
        check_val({pfx, "_memWren"},   32'(memWren),   32'd0);
        check_val({pfx, "_dropCount"}, 32'(dropCount), 32'd0);
        check_val({pfx, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit swept;
        int base;
        int done_base;
        int px, py, pc;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check_val("ready_after_reset", 32'(ready), 32'd1);
        @(posedge clk); #1;

        // Single plot reaches the RAM within two cycles
        send_plot(5, 2, 5);
        acc = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (memWren === 1'b1 && memAddr == 15'd325 && memData == 3'd5) acc = 1'b1;
            @(posedge clk); #1;
        end
        check_val("t1_write_latency", 32'(acc), 32'd1);
        wait_idle();

        // Out-of-range plots and drop counter saturation
        send_plot(160, 0, 1);
        send_plot(0, 120, 2);
        check_val("t2_drop_two", 32'(dropCount), 32'(model_drop));
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) send_plot($urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7));
            else            send_plot($urandom_range(0, 255), $urandom_range(120, 127), $urandom_range(0, 7));
        end
        check_val("t2_drop_saturated", 32'(dropCount), 32'(model_drop));
        check_val("t2_drop_is_255", 32'(dropCount), 32'd255);

        // Scan read, then a plot whose write collides with scan requests
        scan_read(325);
        plot = 1'b1; x = 8'd9; y = 7'd9; color = 3'd1;
        scanReq = 1'b1; scanAddr = 15'd325;
        @(negedge clk); acc = (ready === 1'b1);
        check_val("t4_ready", 32'(ready), 32'd1);
        @(posedge clk);
        if (acc) model_accept(9, 9, 1);
        #1; plot = 1'b0;
        @(negedge clk);
        check_val("t4_defer_n1", 32'(memWren), 32'd0);
        @(posedge clk); #1;
        scanReq = 1'b0;
        @(negedge clk);
        check_val("t4_defer_n2", 32'(memWren), 32'd0);
        check_val("t4_scan_data", 32'(scanData), 32'(fb[325]));
        @(posedge clk); #1;
        wait_idle();

        // Continuous scanout fills the FIFO; draining preserves order
        scanReq = 1'b1; scanAddr = 15'd0;
        for (int i = 0; i < 4; i++) send_plot($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7));
        px = $urandom_range(0, W - 1); py = $urandom_range(0, H - 1); pc = $urandom_range(0, 7);
        x = 8'(px); y = 7'(py); color = 3'(pc); plot = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t3_full_ready", 32'(ready), 32'd0);
            check_val("t3_full_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        scanReq = 1'b0;
        send_plot(px, py, pc);
        wait_idle();

        // Randomized plots mixed with random scanout traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); acc = plot && (ready === 1'b1);
            @(posedge clk);
            if (acc) model_accept(int'(x), int'(y), int'(color));
            #1;
            if (acc || !plot) begin
                plot = 1'($urandom_range(0, 1));
                x = 8'($urandom_range(0, 175));
                y = 7'($urandom_range(0, 127));
                color = 3'($urandom_range(0, 7));
            end
            scanReq = ($urandom_range(0, 3) == 0);
            scanAddr = 15'($urandom_range(0, NPIX - 1));
        end
        plot = 1'b0; scanReq = 1'b0;
        wait_idle();
        check_val("rand_drop", 32'(dropCount), 32'(model_drop));
        for (int i = 0; i < 6; i++) scan_read(written_addrs[$urandom_range(0, written_addrs.size() - 1)]);

        // Full clear discards a preloaded FIFO and a simultaneous plot
        scanReq = 1'b1;
        send_plot(10, 10, 3);
        send_plot(11, 10, 4);
        clear = 1'b1; plot = 1'b1; x = 8'd1; y = 7'd1; color = 3'd7;
        @(negedge clk);
        check_val("t5_ready_with_clear", 32'(ready), 32'd1);
        @(posedge clk);
        model_clear();
        done_base = done_count;
        #1; clear = 1'b0; plot = 1'b0; scanReq = 1'b0;
        swept = 1'b0;
        for (int n = 0; n < 40000 && !swept; n++) begin
            @(negedge clk); #1;
            if (exp_q.size() != 0) begin
                check_val("t5_ready_in_clear", 32'(ready), 32'd0);
                @(posedge clk); #1;
                scanReq = ($urandom_range(0, 7) == 0);
                clear = (exp_q.size() > 2) && ($urandom_range(0, 63) == 0);
            end else begin
                check_val("t5_ready_after_clear", 32'(ready), 32'd1);
                swept = 1'b1;
            end
        end
        @(posedge clk); #1;
        scanReq = 1'b0; clear = 1'b0;
        check_val("t5_sweep_pending", 32'(exp_q.size()), 32'd0);
        check_val("t5_done_pulses", 32'(done_count - done_base), 32'd1);
        wait_idle();
        scan_read(19199);

        // Reset in the middle of a clear sweep
        clear = 1'b1;
        @(posedge clk);
        model_clear();
        #1; clear = 1'b0;
        base = wr_count;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if (wr_count - base >= 1001) break;
        end
        check_val("t6_sweep_progress", 32'(wr_count - base >= 1001), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        model_drop = 0;
        done_base = done_count;
        @(negedge clk);
        check_reset_state("t6_reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_val("t6_no_done", 32'(done_count - done_base), 32'd0);
        check_val("t6_busy", 32'(busy), 32'd0);
        send_plot(7, 3, 6);
        wait_idle();
        scan_read(487);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
